// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-side program-counter generator.
// Default widths, vectors and the redirect source encoding.
package pc_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam int          IALIGN_DEF       = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_TRAP,
    SRC_PEND
  } redirect_src_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-deep pending redirect slot used while fetch is stalled.
// Newer entries replace older ones unless a trap is already held.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WR,
  input  logic [XLEN-1:0] WR_TARGET,
  input  logic            WR_TRAP,
  input  logic            CLR,
  output logic            VALID,
  output logic [XLEN-1:0] TARGET,
  output logic            IS_TRAP
);

  logic keep_trap;

  assign keep_trap = VALID && IS_TRAP && !WR_TRAP;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      VALID   <= 1'b0;
      TARGET  <= '0;
      IS_TRAP <= 1'b0;
    end else if (CLR) begin
      VALID   <= 1'b0;
      IS_TRAP <= 1'b0;
    end else if (WR && !keep_trap) begin
      VALID   <= 1'b1;
      TARGET  <= WR_TARGET;
      IS_TRAP <= WR_TRAP;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch program-counter generator: sequential, branch, jump and trap
// redirects with misalignment trapping and a stall-safe pending slot.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int              IALIGN       = IALIGN_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            BUSY_WAIT,
  input  logic            CON_BRANCH,
  input  logic [XLEN-1:0] BRANCH_BASE,
  input  logic [XLEN-1:0] BRANCH_OFFSET,
  input  logic            JUMP,
  input  logic [XLEN-1:0] JUMP_BASE,
  input  logic [XLEN-1:0] JUMP_OFFSET,
  input  logic            TRAP,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_4,
  output logic            PC_VALID,
  output logic            FLUSH,
  output logic            MISALIGN,
  output logic [XLEN-1:0] MISALIGN_ADDR,
  output logic            PENDING
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] BIT0_CLR   = ~XLEN'(1);

  redirect_src_t   src;
  redirect_src_t   sel;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jp_tgt;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] req_tgt;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] mis_addr_q;
  logic [XLEN-1:0] pend_tgt;
  logic            live;
  logic            req;
  logic            req_trap;
  logic            mis;
  logic            valid_q;
  logic            flush_q;
  logic            mis_q;
  logic            pend_valid;
  logic            pend_trap;
  logic            pend_wr;
  logic            pend_clr;

  assign live = valid_q;

  always_comb begin
    br_tgt  = BRANCH_BASE + BRANCH_OFFSET;
    jp_tgt  = (JUMP_BASE + JUMP_OFFSET) & BIT0_CLR;
    src     = SRC_SEQ;
    raw_tgt = '0;
    priority case (1'b1)
      TRAP: begin
        src     = SRC_TRAP;
        raw_tgt = TRAP_VECTOR;
      end
      JUMP: begin
        src     = SRC_JUMP;
        raw_tgt = jp_tgt;
      end
      CON_BRANCH: begin
        src     = SRC_BRANCH;
        raw_tgt = br_tgt;
      end
      default: ;
    endcase
    req      = live && (src != SRC_SEQ);
    mis      = req && (src != SRC_TRAP) && (|(raw_tgt & ALIGN_MASK));
    req_trap = (src == SRC_TRAP) || mis;
    req_tgt  = req_trap ? TRAP_VECTOR : raw_tgt;
  end

  // A live request always beats the buffered one.
  always_comb begin
    sel  = SRC_SEQ;
    pc_d = pc_q;
    if (live && !BUSY_WAIT) begin
      if (req) begin
        sel  = src;
        pc_d = req_tgt;
      end else if (pend_valid) begin
        sel  = SRC_PEND;
        pc_d = pend_tgt;
      end else begin
        pc_d = pc_q + STEP;
      end
    end
  end

  assign pend_wr  = live && BUSY_WAIT && req;
  assign pend_clr = live && !BUSY_WAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      flush_q <= (sel != SRC_SEQ);
      mis_q   <= mis;
      if (mis) mis_addr_q <= raw_tgt;
    end
  end

  pc_redirect_buf #(
    .XLEN(XLEN)
  ) u_buf (
    .CLK      (CLK),
    .RESET    (RESET),
    .WR       (pend_wr),
    .WR_TARGET(req_tgt),
    .WR_TRAP  (req_trap),
    .CLR      (pend_clr),
    .VALID    (pend_valid),
    .TARGET   (pend_tgt),
    .IS_TRAP  (pend_trap)
  );

  assign PC            = pc_q;
  assign PC_4          = pc_q + STEP;
  assign PC_VALID      = valid_q;
  assign FLUSH         = flush_q;
  assign MISALIGN      = mis_q;
  assign MISALIGN_ADDR = mis_addr_q;
  assign PENDING       = pend_valid;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios then random traffic,
// all checked against a behavioural model of the redirect rules.
module tb_pc_gen_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        BUSY_WAIT = 1'b0;
  logic        CON_BRANCH = 1'b0;
  logic [31:0] BRANCH_BASE = '0;
  logic [31:0] BRANCH_OFFSET = '0;
  logic        JUMP = 1'b0;
  logic [31:0] JUMP_BASE = '0;
  logic [31:0] JUMP_OFFSET = '0;
  logic        TRAP = 1'b0;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic        PC_VALID;
  logic        FLUSH;
  logic        MISALIGN;
  logic [31:0] MISALIGN_ADDR;
  logic        PENDING;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_flush;
  logic        m_mis;
  logic [31:0] m_mis_addr;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic        m_pend_trap;

  pc_gen_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BUSY_WAIT    (BUSY_WAIT),
    .CON_BRANCH   (CON_BRANCH),
    .BRANCH_BASE  (BRANCH_BASE),
    .BRANCH_OFFSET(BRANCH_OFFSET),
    .JUMP         (JUMP),
    .JUMP_BASE    (JUMP_BASE),
    .JUMP_OFFSET  (JUMP_OFFSET),
    .TRAP         (TRAP),
    .PC           (PC),
    .PC_4         (PC_4),
    .PC_VALID     (PC_VALID),
    .FLUSH        (FLUSH),
    .MISALIGN     (MISALIGN),
    .MISALIGN_ADDR(MISALIGN_ADDR),
    .PENDING      (PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_valid = 0; m_flush = 0; m_mis = 0;
    m_mis_addr = 0; m_pend = 0; m_pend_tgt = 0; m_pend_trap = 0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    bit has, trp;
    has = 0; trp = 0; t = 0;
    m_flush = 0;
    m_mis = 0;
    if (!m_valid) begin
      m_valid = 1;
      return;
    end
    if (TRAP) begin
      has = 1; trp = 1; t = TV;
    end else if (JUMP) begin
      has = 1; t = (JUMP_BASE + JUMP_OFFSET) & 32'hFFFF_FFFE;
    end else if (CON_BRANCH) begin
      has = 1; t = BRANCH_BASE + BRANCH_OFFSET;
    end
    if (has && !trp && (t % 4 != 0)) begin
      m_mis = 1; m_mis_addr = t; t = TV; trp = 1;
    end
    if (!BUSY_WAIT) begin
      if (has) begin
        m_pc = t; m_flush = 1; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_pend_tgt; m_flush = 1; m_pend = 0;
      end else begin
        m_pc = m_pc + 4;
      end
    end else if (has && !(m_pend && m_pend_trap && !trp)) begin
      m_pend = 1; m_pend_tgt = t; m_pend_trap = trp;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, PC, m_pc);
    chk({tag, ".pc4"}, PC_4, m_pc + 32'd4);
    chk({tag, ".valid"}, 32'(PC_VALID), 32'(m_valid));
    chk({tag, ".flush"}, 32'(FLUSH), 32'(m_flush));
    chk({tag, ".mis"}, 32'(MISALIGN), 32'(m_mis));
    chk({tag, ".misaddr"}, MISALIGN_ADDR, m_mis_addr);
    chk({tag, ".pend"}, 32'(PENDING), 32'(m_pend));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic idle();
    BUSY_WAIT = 0; CON_BRANCH = 0; JUMP = 0; TRAP = 0;
  endtask

  task automatic do_reset();
    RESET = 0;
    #2;
    model_reset();
    chk_all("rst");
    @(posedge CLK);
    #1;
    RESET = 1;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst.pc_const", PC, RV);
    chk("rst.pc4_const", PC_4, RV + 4);

    // 1: release and idle
    tick("t1a"); chk("t1.pc0", PC, 32'h0);
    chk("t1.valid", 32'(PC_VALID), 32'd1);
    tick("t1b"); chk("t1.pc4", PC, 32'h4);
    tick("t1c"); chk("t1.pc8", PC, 32'h8);
    tick("t1d"); chk("t1.pcC", PC, 32'hC);

    // 2: backward branch from 0x40
    JUMP = 1; JUMP_BASE = 32'h40; JUMP_OFFSET = 0;
    tick("t2j"); chk("t2.pc40", PC, 32'h40);
    idle(); CON_BRANCH = 1;
    BRANCH_BASE = 32'h3C; BRANCH_OFFSET = 32'hFFFF_FFF0;
    tick("t2b"); chk("t2.pc2c", PC, 32'h2C);
    chk("t2.flush", 32'(FLUSH), 32'd1);
    idle();
    tick("t2c"); chk("t2.pc30", PC, 32'h30);
    chk("t2.noflush", 32'(FLUSH), 32'd0);

    // 3: trap beats jump and branch
    TRAP = 1; JUMP = 1; CON_BRANCH = 1;
    JUMP_BASE = 32'h200; JUMP_OFFSET = 0;
    tick("t3a"); chk("t3.pc", PC, TV);
    idle();
    tick("t3b"); chk("t3.flush_end", 32'(FLUSH), 32'd0);

    // 4: jump bit0 clear, misaligned branch
    JUMP = 1; JUMP_BASE = 32'h1001; JUMP_OFFSET = 0;
    tick("t4a"); chk("t4.pc1000", PC, 32'h1000);
    chk("t4.nomis", 32'(MISALIGN), 32'd0);
    idle(); CON_BRANCH = 1;
    BRANCH_BASE = 32'h1000; BRANCH_OFFSET = 32'h2;
    tick("t4b"); chk("t4.pctrap", PC, TV);
    chk("t4.mis", 32'(MISALIGN), 32'd1);
    chk("t4.addr", MISALIGN_ADDR, 32'h1002);
    idle();
    tick("t4c"); chk("t4.addr_hold", MISALIGN_ADDR, 32'h1002);

    // 5: stalled redirects with sticky trap
    BUSY_WAIT = 1; CON_BRANCH = 1;
    BRANCH_BASE = 32'h80; BRANCH_OFFSET = 0;
    tick("t5a"); chk("t5.hold", PC, 32'h104);
    chk("t5.pend", 32'(PENDING), 32'd1);
    CON_BRANCH = 0; TRAP = 1;
    tick("t5b");
    TRAP = 0; JUMP = 1; JUMP_BASE = 32'h200; JUMP_OFFSET = 0;
    tick("t5c"); chk("t5.hold3", PC, 32'h104);
    idle();
    tick("t5d"); chk("t5.pc", PC, TV);
    chk("t5.flush", 32'(FLUSH), 32'd1);
    chk("t5.pend0", 32'(PENDING), 32'd0);

    // 6: wrap, then reset with a pending entry
    JUMP = 1; JUMP_BASE = 32'hFFFF_FFFC; JUMP_OFFSET = 0;
    tick("t6a"); chk("t6.pc4wrap", PC_4, 32'h0);
    idle();
    tick("t6b"); chk("t6.wrap", PC, 32'h0);
    chk("t6.pc4", PC_4, 32'h4);
    BUSY_WAIT = 1; CON_BRANCH = 1;
    BRANCH_BASE = 32'h80; BRANCH_OFFSET = 0;
    tick("t6c"); chk("t6.pend", 32'(PENDING), 32'd1);
    idle();
    #2;
    RESET = 0;
    #1;
    chk("t6.arst_pc", PC, RV);
    chk("t6.arst_pend", 32'(PENDING), 32'd0);
    chk("t6.arst_valid", 32'(PC_VALID), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1;
    tick("t6d");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      BUSY_WAIT     = ($urandom_range(0, 3) == 0);
      TRAP          = ($urandom_range(0, 15) == 0);
      JUMP          = ($urandom_range(0, 5) == 0);
      CON_BRANCH    = ($urandom_range(0, 4) == 0);
      BRANCH_BASE   = $urandom & 32'h0000_FFFC;
      BRANCH_OFFSET = ($urandom_range(0, 5) == 0) ?
                      32'($urandom_range(0, 7)) :
                      32'($signed(12'($urandom)) & ~32'd3);
      JUMP_BASE     = $urandom;
      JUMP_OFFSET   = 32'($urandom_range(0, 31));
      tick("rnd");
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
